// File: rtl/mdu_iter.sv
// mdu_iter: iterative RISC-V M-extension multiply/divide unit (RV64M incl. W forms).
//   Radix-2 shift-add multiplier and restoring divider, one step per cycle.
//   Divide-by-zero and signed overflow complete directly from IDLE.
// Ports:
//   clock, reset_n      : rising-edge clock, asynchronous active-low reset
//   flush               : synchronous abort, returns to IDLE and drops the result
//   in_valid / in_ready : request handshake (in_ready only in IDLE)
//   op, word            : funct3 and W-form flag (word ignored when XLEN=32)
//   src1, src2          : multiplicand/dividend, multiplier/divisor
//   out_valid/out_ready : result handshake, result held while out_valid=1
//   result              : registered result
module mdu_iter #(
   parameter int XLEN = 64
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic            word,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   localparam int CW  = $clog2(XLEN + 1);
   // Word-mode dividends are pre-shifted so their MSB sits at the register MSB.
   localparam int WSH = (XLEN == 64) ? 32 : 0;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = {XLEN{v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = '0;
      r[31:0] = v;
      return r;
   endfunction

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              word_q, word_d;
   logic [2:0]        op_q, op_d;
   logic              neg_res_q, neg_res_d;
   logic              neg_rem_q, neg_rem_d;
   logic              fix_ph_q, fix_ph_d;
   // acc: 2N-bit product, or {remainder, quotient/dividend} when dividing.
   logic [2*XLEN-1:0] acc_q, acc_d;
   // opa: left-shifting multiplicand, or divisor magnitude in the low half.
   logic [2*XLEN-1:0] opa_q, opa_d;
   // opb: right-shifting multiplier.
   logic [XLEN-1:0]   opb_q, opb_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              out_valid_q, out_valid_d;

   // Operand preparation (combinational on the request inputs)
   logic            eff_word, s1_signed, s2_signed, neg1, neg2;
   logic [XLEN-1:0] e1, e2, m1, m2, min_neg, sp_res;
   logic            div_zero, div_ovf;

   always_comb begin
      eff_word  = (XLEN == 64) ? word : 1'b0;
      s1_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
      s2_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
      if (eff_word) begin
         e1 = s1_signed ? sext32(src1[31:0]) : zext32(src1[31:0]);
         e2 = s2_signed ? sext32(src2[31:0]) : zext32(src2[31:0]);
      end else begin
         e1 = src1;
         e2 = src2;
      end
      neg1 = s1_signed & e1[XLEN-1];
      neg2 = s2_signed & e2[XLEN-1];
      m1   = neg1 ? -e1 : e1;
      m2   = neg2 ? -e2 : e2;

      min_neg         = '0;
      min_neg[XLEN-1] = 1'b1;
      if (eff_word) begin
         min_neg = sext32(32'h8000_0000);
      end
      div_zero = op[2] && (e2 == '0);
      div_ovf  = op[2] && !op[0] && (e1 == min_neg) && (e2 == '1);

      // op[1] distinguishes rem/remu from div/divu.
      if (div_zero) begin
         sp_res = op[1] ? e1 : '1;
      end else begin
         sp_res = op[1] ? '0 : e1;
      end
      if (eff_word) begin
         sp_res = sext32(sp_res[31:0]);
      end
   end

   // Datapath step helpers
   logic [CW-1:0]   last_cnt;
   logic [XLEN:0]   rem_sh, diff;
   logic [XLEN-1:0] rem_cur, quo_cur, sel;

   always_comb begin
      last_cnt = word_q ? CW'(31) : CW'(XLEN - 1);
      rem_sh   = acc_q[2*XLEN-1:XLEN-1];
      diff     = rem_sh - {1'b0, opa_q[XLEN-1:0]};
      rem_cur  = acc_q[2*XLEN-1:XLEN];
      quo_cur  = acc_q[XLEN-1:0];

      if (op_q[2]) begin
         sel = op_q[1] ? rem_cur : quo_cur;
      end else if (word_q || (op_q == OP_MUL)) begin
         sel = acc_q[XLEN-1:0];
      end else begin
         sel = acc_q[2*XLEN-1:XLEN];
      end
      if (word_q) begin
         sel = sext32(sel[31:0]);
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      word_d      = word_q;
      op_d        = op_q;
      neg_res_d   = neg_res_q;
      neg_rem_d   = neg_rem_q;
      fix_ph_d    = fix_ph_q;
      acc_d       = acc_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      result_d    = result_q;
      out_valid_d = out_valid_q;

      if (flush) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         cnt_d       = '0;
         fix_ph_d    = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  word_d    = eff_word;
                  op_d      = op;
                  neg_res_d = neg1 ^ neg2;
                  neg_rem_d = neg1;
                  cnt_d     = '0;
                  fix_ph_d  = 1'b0;
                  if (div_zero || div_ovf) begin
                     result_d    = sp_res;
                     out_valid_d = 1'b1;
                     state_d     = DONE;
                  end else begin
                     state_d = CALC;
                     opb_d   = m2;
                     if (op[2]) begin
                        acc_d = {{XLEN{1'b0}}, (eff_word ? (m1 << WSH) : m1)};
                        opa_d = {{XLEN{1'b0}}, m2};
                     end else begin
                        acc_d = '0;
                        opa_d = {{XLEN{1'b0}}, m1};
                     end
                  end
               end
            end
            CALC: begin
               if (op_q[2]) begin
                  // Restoring step: keep the shifted remainder when the trial subtract underflows.
                  if (diff[XLEN]) begin
                     acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                  end else begin
                     acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                  end
               end else begin
                  acc_d = acc_q + (opb_q[0] ? opa_q : '0);
                  opa_d = opa_q << 1;
                  opb_d = opb_q >> 1;
               end
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == last_cnt) begin
                  cnt_d   = '0;
                  state_d = FIX;
               end
            end
            FIX: begin
               // Phase 0 applies sign correction in place; phase 1 selects and registers.
               if (!fix_ph_q) begin
                  fix_ph_d = 1'b1;
                  if (op_q[2]) begin
                     acc_d = {(neg_rem_q ? -rem_cur : rem_cur), (neg_res_q ? -quo_cur : quo_cur)};
                  end else begin
                     acc_d = neg_res_q ? -acc_q : acc_q;
                  end
               end else begin
                  fix_ph_d    = 1'b0;
                  result_d    = sel;
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_d = 1'b0;
                  state_d     = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         word_q      <= 1'b0;
         op_q        <= '0;
         neg_res_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         fix_ph_q    <= 1'b0;
         acc_q       <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         word_q      <= word_d;
         op_q        <= op_d;
         neg_res_q   <= neg_res_d;
         neg_rem_q   <= neg_rem_d;
         fix_ph_q    <= fix_ph_d;
         acc_q       <= acc_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed bench for mdu_iter (XLEN=64).
module tb_mdu_iter;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  op = 3'b000;
   logic        word = 1'b0;
   logic [63:0] src1 = '0;
   logic [63:0] src2 = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] result;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   mdu_iter #(.XLEN(64)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .word      (word),
      .src1      (src1),
      .src2      (src2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic w, input logic [63:0] a, input logic [63:0] b);
      int t;
      t = 0;
      while (!in_ready && t < 200) begin
         @(posedge clock); #1;
         t++;
      end
      if (!in_ready) check("issue_timeout", 64'(in_ready), 64'd1);
      op = o; word = w; src1 = a; src2 = b;
      in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input int maxc, output int lat);
      lat = 0;
      while (!out_valid && lat < maxc) begin
         @(posedge clock); #1;
         lat++;
      end
   endtask

   // exp_lat < 0 skips the latency comparison.
   task automatic run(input string tag, input logic [2:0] o, input logic w,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] exp, input int exp_lat);
      int lat;
      issue(o, w, a, b);
      check({tag, "_busy"}, 64'(in_ready), 64'd0);
      wait_valid(100, lat);
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      if (exp_lat >= 0) check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_res"}, result, exp);
      @(posedge clock); #1;
      check({tag, "_idle"}, 64'(in_ready), 64'd1);
      check({tag, "_vdrop"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      int lat;
      bit seen;

      // Reset state
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_result", result, 64'd0);
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      @(posedge clock); #1;

      // Multiply
      run("mulh", 3'b001, 1'b0, ONES, 64'd2, ONES, 66);
      run("mulhu", 3'b011, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 66);
      run("mul", 3'b000, 1'b0, ONES, ONES, 64'd1, 66);
      run("mulhsu", 3'b010, 1'b0, ONES, 64'd5, ONES, 66);

      // Divide special cases complete on the accept edge
      run("div_zero", 3'b100, 1'b0, 64'd7, 64'd0, ONES, 0);
      run("rem_ovf", 3'b110, 1'b0, 64'h8000_0000_0000_0000, ONES, 64'd0, 0);
      run("remu_zero", 3'b111, 1'b0, 64'd9, 64'd0, 64'd9, 0);

      // Word forms
      run("divw_min", 3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, -1);
      run("divw", 3'b100, 1'b1, 64'd100, 64'd7, 64'd14, 34);
      run("mulw_hu", 3'b011, 1'b1, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0001_0001, ONES, 34);
      run("div_neg", 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);

      // Signed remainder with backpressure
      out_ready = 1'b0;
      issue(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
      wait_valid(100, lat);
      check("rem_bp_lat", 64'(lat), 64'd66);
      check("rem_bp_res", result, ONES);
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
         check("rem_bp_hold", result, ONES);
         check("rem_bp_busy", 64'(in_ready), 64'd0);
         check("rem_bp_valid", 64'(out_valid), 64'd1);
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      check("rem_bp_idle", 64'(in_ready), 64'd1);
      check("rem_bp_vdrop", 64'(out_valid), 64'd0);

      // Flush at CALC cycle 20
      issue(3'b101, 1'b0, 64'd1000, 64'd3);
      repeat (20) @(posedge clock);
      #1 flush = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0;
      check("flush_idle", 64'(in_ready), 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clock); #1;
         if (out_valid) seen = 1'b1;
      end
      check("flush_no_valid", 64'(seen), 64'd0);

      // A request under flush is ignored
      op = 3'b100; word = 1'b0; src1 = 64'd5; src2 = 64'd0;
      flush = 1'b1; in_valid = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0; in_valid = 1'b0;
      check("flush_req_ready", 64'(in_ready), 64'd1);
      check("flush_req_valid", 64'(out_valid), 64'd0);
      check("flush_keeps_res", result, ONES);

      // Asynchronous reset mid-CALC
      issue(3'b000, 1'b0, 64'd3, 64'd5);
      repeat (10) @(posedge clock);
      #3 reset_n = 1'b0;
      #1;
      check("arst_valid", 64'(out_valid), 64'd0);
      check("arst_result", result, 64'd0);
      check("arst_ready", 64'(in_ready), 64'd1);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      @(posedge clock); #1;
      run("remu_after_rst", 3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 66);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
